// File: rtl/fsm_9_decoder.sv
// Receive-side decoder for the 2-bit toggle-code Moore encoder: recovers x, packs bytes LSB-first, counts code violations.
// Latency: a sample accepted at edge N shows its x_out/x_valid (and byte_valid on the 8th bit) in cycle N+1.
// No back-pressure: one bit per qualified cycle; sample_en low freezes all state and forces pulses to 0.
module fsm_9_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 y_in,
  input  logic                 y1_in,
  output logic                 x_out,
  output logic                 x_valid,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  s;
  logic [1:0]  d;
  logic [1:0]  prev;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        do_lock;
  logic        do_bit;
  logic        do_err;
  logic        bit_val;

  // Encoder state is recovered directly from its Moore outputs.
  assign s = {~y_in, y1_in};
  // Exactly one flipped bit is legal; which bit flipped tells us x.
  assign d = s ^ prev;

  // locked comes straight off the state register, so it is registered too.
  assign locked = (state == TRACK);

  // Next-state and per-cycle action decode.
  always_comb begin
    state_nx = state;
    do_lock  = 1'b0;
    do_bit   = 1'b0;
    do_err   = 1'b0;
    bit_val  = 1'b0;
    if (sample_en) begin
      case (state)
        SYNC: begin
          // The sample that caused a violation is never seen here, so it
          // cannot be reused for sync even if it happened to read as a.
          if (s == 2'b00) begin
            state_nx = TRACK;
            do_lock  = 1'b1;
          end
        end
        TRACK: begin
          if (d == 2'b01 || d == 2'b10) begin
            do_bit  = 1'b1;
            bit_val = (d == 2'b01);
          end else begin
            do_err   = 1'b1;
            state_nx = SYNC;
          end
        end
        default: state_nx = SYNC;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nx;
  end

  // Datapath: previous-sample tracking, deserializer, pulses and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= 2'b00;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      x_out      <= 1'b0;
      x_valid    <= 1'b0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      x_valid    <= do_bit;
      byte_valid <= do_bit && (bit_cnt == 3'd7);
      err        <= do_err;
      if (do_lock) begin
        prev    <= 2'b00;
        bit_cnt <= 3'd0;
      end
      if (do_bit) begin
        x_out          <= bit_val;
        prev           <= s;
        shreg[bit_cnt] <= bit_val;
        bit_cnt        <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_out <= {bit_val, shreg[6:0]};
      end
      if (do_err) begin
        // Partial byte is dropped; stale shreg bits are all overwritten
        // before the next byte completes.
        bit_cnt <= 3'd0;
        if (err_cnt != {ERR_CNT_W{1'b1}}) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fsm_9_decoder.sv
// Self-checking bench: directed test-plan sequences plus a randomized phase, all checked cycle by cycle against a behavioural model.
// Outputs are sampled 1 time unit after each rising edge.
// The design never back-pressures, so every step is a single clock.
module tb_fsm_9_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_en = 1'b0;
  logic       y_in = 1'b0;
  logic       y1_in = 1'b0;
  logic       x_out, x_valid, byte_valid, locked, err;
  logic [7:0] byte_out, err_cnt;
  logic       x_out2, x_valid2, byte_valid2, locked2, err2;
  logic [7:0] byte_out2;
  logic [1:0] err_cnt2;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  bit   m_locked;
  int   m_prev;
  bit   m_bits[$];
  int   m_byte;
  int   m_cnt, m_cnt2;
  bit   m_xv, m_xo, m_bv, m_err;
  int   bv_seen;
  logic [1:0] enc;

  fsm_9_decoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .y_in(y_in), .y1_in(y1_in),
    .x_out(x_out), .x_valid(x_valid), .byte_out(byte_out), .byte_valid(byte_valid),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  fsm_9_decoder #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .y_in(y_in), .y1_in(y1_in),
    .x_out(x_out2), .x_valid(x_valid2), .byte_out(byte_out2), .byte_valid(byte_valid2),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model reaction to one clock edge, written in terms of encoder states and a bit queue.
  task automatic model_edge(input bit r, input bit en, input bit y, input bit y1);
    int s, d, b;
    m_xv = 0; m_bv = 0; m_err = 0;
    if (r) begin
      m_locked = 0; m_prev = 0; m_bits.delete(); m_byte = 0;
      m_cnt = 0; m_cnt2 = 0; m_xo = 0;
      return;
    end
    if (!en) return;
    s = (y ? 0 : 2) + (y1 ? 1 : 0);
    if (!m_locked) begin
      if (s == 0) begin
        m_locked = 1; m_prev = 0; m_bits.delete();
      end
      return;
    end
    d = s ^ m_prev;
    if (d == 1 || d == 2) begin
      m_xv = 1; m_xo = (d == 1); m_prev = s;
      m_bits.push_back(m_xo);
      if (m_bits.size() == 8) begin
        b = 0;
        foreach (m_bits[i]) b += m_bits[i] * (1 << i);
        m_byte = b; m_bv = 1; m_bits.delete();
      end
    end else begin
      m_err = 1; m_locked = 0; m_bits.delete();
      m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
      m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
    end
  endtask

  // Apply inputs for one cycle, advance the model, then compare every output.
  task automatic step(input bit r, input bit en, input bit y, input bit y1);
    rst = r; sample_en = en; y_in = y; y1_in = y1;
    @(posedge clk);
    model_edge(r, en, y, y1);
    #1;
    chk("x_valid", x_valid, m_xv);
    if (m_xv || r) chk("x_out", x_out, m_xo);
    chk("byte_valid", byte_valid, m_bv);
    chk("byte_out", byte_out, m_byte);
    chk("locked", locked, m_locked);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_cnt);
    chk("err_cnt_w2", err_cnt2, m_cnt2);
    chk("err_w2", err2, m_err);
    if (byte_valid) bv_seen++;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    enc = 2'b00;
  endtask

  // Lock sample: encoder reset state a reads as y=1, y1=0.
  task automatic send_lock();
    enc = 2'b00;
    step(0, 1, 1, 0);
  endtask

  // Drive the model encoder one cycle with input x.
  task automatic send_x(input bit x);
    enc = enc ^ (x ? 2'b01 : 2'b10);
    step(0, 1, ~enc[1], enc[0]);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      send_x(v[i]);
      if (gaps) begin
        for (int g = 0; g < 1 + (i % 3); g++) step(0, 0, 1'($urandom), 1'($urandom));
      end
    end
  endtask

  initial begin
    // Reset values.
    do_reset();
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_err_cnt", err_cnt, 8'h00);

    // Lock and decode: x_out 1,0,1,1.
    step(0, 1, 1, 0);
    chk("lock_locked", locked, 1'b1);
    step(0, 1, 1, 1);
    chk("dec_bit0", x_out, 1'b1);
    step(0, 1, 0, 1);
    chk("dec_bit1", x_out, 1'b0);
    step(0, 1, 0, 0);
    chk("dec_bit2", x_out, 1'b1);
    step(0, 1, 0, 1);
    chk("dec_bit3", x_out, 1'b1);
    chk("dec_no_err", err_cnt, 8'h00);

    // Byte assembly, straight then with gaps.
    do_reset();
    send_lock();
    bv_seen = 0;
    send_byte(8'hA5, 0);
    chk("a5_byte", byte_out, 8'hA5);
    chk("a5_one_pulse", bv_seen, 1);
    do_reset();
    send_lock();
    bv_seen = 0;
    send_byte(8'hA5, 1);
    chk("a5_gap_byte", byte_out, 8'hA5);
    chk("a5_gap_one_pulse", bv_seen, 1);
    chk("a5_gap_no_err", err_cnt, 8'h00);

    // Violations and saturation.
    do_reset();
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("viol1_err", err, 1'b1);
    chk("viol1_cnt", err_cnt, 8'd1);
    chk("viol1_unlocked", locked, 1'b0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    chk("viol2_cnt", err_cnt, 8'd2);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 0);
      step(0, 1, 1, 0);
      chk("sat_err_pulse", err2, 1'b1);
    end
    chk("sat_cnt_w2", err_cnt2, 2'd3);
    chk("sat_cnt_w8", err_cnt, 8'd5);

    // Reset mid-byte, then a clean 0x3C.
    do_reset();
    send_lock();
    for (int i = 0; i < 5; i++) send_x(1'($urandom));
    do_reset();
    chk("midrst_locked", locked, 1'b0);
    chk("midrst_x_out", x_out, 1'b0);
    send_lock();
    bv_seen = 0;
    send_byte(8'h3C, 0);
    chk("3c_byte", byte_out, 8'h3C);
    chk("3c_one_pulse", bv_seen, 1);

    // Randomized traffic: legal bits, gaps, garbage samples, re-locks, rare resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (!m_locked && r < 50) send_lock();
      else if (r < 75) send_x(1'($urandom));
      else if (r < 88) step(0, 0, 1'($urandom), 1'($urandom));
      else if (r < 98) step(0, 1, 1'($urandom), 1'($urandom));
      else do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
